// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory controller: access-size encodings,
// FSM state type and the byte-strobe helper.
package lsu_pkg;

    localparam logic [2:0] MODE_B = 3'b001;
    localparam logic [2:0] MODE_H = 3'b010;
    localparam logic [2:0] MODE_W = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // Any non-byte, non-half mode is handled as a full word.
    function automatic logic [3:0] lsu_strobe(input logic [2:0] mode, input logic [1:0] addr_lo);
        case (mode)
            MODE_B:  lsu_strobe = 4'b0001 << addr_lo;
            MODE_H:  lsu_strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: lsu_strobe = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/replication and load extract/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        wstrb = lsu_strobe(mode, addr_lo);
        case (mode)
            MODE_B:  wdata_rep = {4{wdata[7:0]}};
            MODE_H:  wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (mode)
            MODE_B:  rdata_ext = is_unsigned ? {24'd0, byte_sel} : 32'(byte_sel);
            MODE_H:  rdata_ext = is_unsigned ? {16'd0, half_sel} : 32'(half_sel);
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory controller: one access per request, one word-aligned memory transaction,
// response timeout. Define LSU_ALIGN_CHECK_EN to reject misaligned or non-one-hot accesses.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_mode,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    lsu_state_e        state_q, state_d;
    logic              we_q, uns_q, err_q;
    logic [2:0]        mode_q, mode_eff;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [15:0]       cnt_q;
    logic              accept, capture, timeout, cnt_clr, chk_err;
    logic [3:0]        wstrb;
    logic [31:0]       wdata_rep, rdata_ext;

    always_comb begin
        if (req_mode == MODE_B || req_mode == MODE_H) mode_eff = req_mode;
        else                                          mode_eff = MODE_W;
    end

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        chk_err = (req_mode != MODE_B && req_mode != MODE_H && req_mode != MODE_W)
               || (req_mode == MODE_H && req_addr[0])
               || (req_mode == MODE_W && req_addr[1:0] != 2'b00);
    end
`else
    assign chk_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        timeout = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                accept  = 1'b1;
                state_d = chk_err ? ST_RESP : ST_REQ;
            end
            ST_REQ: if (mem_ready) begin
                if (we_q) begin
                    state_d = ST_RESP;
                end else if (mem_rvalid) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_clr = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q == TMO) begin
                    timeout = 1'b1;
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state: FSM, timeout counter, error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cnt_clr)                 cnt_q <= '0;
            else if (state_q == ST_WAIT) cnt_q <= cnt_q + 16'd1;
            if (accept)       err_q <= chk_err;
            else if (timeout) err_q <= 1'b1;
        end
    end

    // Datapath capture: request fields at accept, load result at capture
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            mode_q  <= mode_eff;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
        if (accept || timeout) rdata_q <= '0;
        else if (capture)      rdata_q <= rdata_ext;
    end

    lsu_align u_align (
        .mode        (mode_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (mem_rdata),
        .wstrb       (wstrb),
        .wdata_rep   (wdata_rep),
        .rdata_ext   (rdata_ext)
    );

    // Outputs are gated by state so idle/reset values are always zero.
    assign req_ready = (state_q == ST_IDLE);
    assign mem_valid = (state_q == ST_REQ);
    assign mem_we    = mem_valid && we_q;
    assign mem_addr  = mem_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wstrb = mem_we ? wstrb : 4'b0000;
    assign mem_wdata = mem_valid ? wdata_rep : 32'd0;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl (TIMEOUT=4); covers LSU_ALIGN_CHECK_EN either way.
module tb_lsu_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [2:0]  req_mode = 3'b100;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, mem_valid, mem_we, rsp_valid, rsp_err;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h5A5A_5A5A, rsp_rdata;
    logic [3:0]  mem_wstrb;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_mode(req_mode), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_rsp();
        int guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            chk("rsp_missing", sb.size(), 0);
            sb.delete();
        end
    endtask

    // rdy: cycles mem_ready is held low; rd: cycles from handshake to rvalid (-1 = never)
    task automatic do_access(input logic we, input logic [2:0] mode, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int rdy, input int rd, input logic [31:0] rv,
                             input logic e_err, input logic [31:0] e_rdata,
                             input logic [31:0] e_addr, input logic [3:0] e_strb,
                             input logic [31:0] e_wdata);
        int c0, h;
        exp_t e;
        @(negedge clk);
        chk("req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_mode = mode; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        c0 = cyc;
        h  = c0 + 1 + rdy;
        e.err = e_err; e.rdata = e_rdata;
        if (e_err && rd == 0 && rdy == 0 && e_addr == 32'hFFFF_FFFF) e.cyc = c0 + 1;
        else if (we)    e.cyc = h + 1;
        else if (rd < 0) e.cyc = h + 2 + TO;
        else            e.cyc = h + rd + 1;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        if (e_addr == 32'hFFFF_FFFF) begin
            chk("err_no_mem_c1", {31'd0, mem_valid}, 32'd0);
            @(negedge clk);
            chk("err_no_mem_c2", {31'd0, mem_valid}, 32'd0);
        end else begin
            for (int i = 0; i <= rdy; i++) begin
                chk("mem_valid", {31'd0, mem_valid}, 32'd1);
                chk("mem_we", {31'd0, mem_we}, {31'd0, we});
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e_strb});
                if (we) chk("mem_wdata", mem_wdata, e_wdata);
                if (i == rdy) begin
                    mem_ready = 1'b1;
                    if (rd == 0 && !we) begin mem_rvalid = 1'b1; mem_rdata = rv; end
                end
                @(negedge clk);
                mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
            end
            for (int i = 1; i <= rd; i++) begin
                if (i == rd) begin mem_rvalid = 1'b1; mem_rdata = rv; end
                @(negedge clk);
                mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
            end
        end
        wait_rsp();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    endtask

    localparam logic [31:0] NOMEM = 32'hFFFF_FFFF;

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Stores: byte, half, word
        do_access(1, 3'b001, 0, 32'h1003, 32'h0000_00A5, 0, 0, 0, 0, 0, 32'h1000, 4'b1000, 32'hA5A5_A5A5);
        do_access(1, 3'b010, 0, 32'h1002, 32'h0000_BEEF, 1, 0, 0, 0, 0, 32'h1000, 4'b1100, 32'hBEEF_BEEF);
        do_access(1, 3'b100, 0, 32'h1008, 32'h1234_5678, 0, 0, 0, 0, 0, 32'h1008, 4'b1111, 32'h1234_5678);

        // Loads: half signed/unsigned with late rvalid, word with delayed ready, bytes
        do_access(0, 3'b010, 0, 32'h2002, 0, 0, 3, 32'h8001_1234, 0, 32'hFFFF_8001, 32'h2000, 4'b0000, 0);
        do_access(0, 3'b010, 1, 32'h2002, 0, 0, 3, 32'h8001_1234, 0, 32'h0000_8001, 32'h2000, 4'b0000, 0);
        do_access(0, 3'b100, 0, 32'h4000, 0, 4, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 32'h4000, 4'b0000, 0);
        do_access(0, 3'b001, 0, 32'h6001, 0, 0, 1, 32'h0000_8000, 0, 32'hFFFF_FF80, 32'h6000, 4'b0000, 0);
        do_access(0, 3'b001, 1, 32'h6003, 0, 0, 0, 32'hAB00_0000, 0, 32'h0000_00AB, 32'h6000, 4'b0000, 0);

`ifdef LSU_ALIGN_CHECK_EN
        do_access(0, 3'b100, 0, 32'h3001, 0, 0, 0, 0, 1, 0, NOMEM, 4'b0000, 0);
        do_access(0, 3'b011, 0, 32'h3000, 0, 0, 0, 0, 1, 0, NOMEM, 4'b0000, 0);
        do_access(1, 3'b010, 0, 32'h3001, 32'h1, 0, 0, 0, 1, 0, NOMEM, 4'b0000, 0);
`else
        do_access(0, 3'b100, 0, 32'h3001, 0, 0, 0, 32'h1122_3344, 0, 32'h1122_3344, 32'h3000, 4'b0000, 0);
        do_access(0, 3'b011, 0, 32'h3004, 0, 0, 1, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 32'h3004, 4'b0000, 0);
        do_access(0, 3'b010, 0, 32'h3003, 0, 0, 0, 32'h7FFF_0000, 0, 32'h0000_7FFF, 32'h3000, 4'b0000, 0);
`endif

        // Timeout, then a late rvalid in IDLE must be ignored
        do_access(0, 3'b100, 0, 32'h5000, 0, 0, -1, 0, 1, 0, 32'h5000, 4'b0000, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("late_rvalid_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("late_rvalid_mem", {31'd0, mem_valid}, 32'd0);
        @(negedge clk);
        chk("late_rvalid_rsp2", {31'd0, rsp_valid}, 32'd0);

        // Reset while in WAIT abandons the access silently
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_mode = 3'b100; req_addr = 32'h7000;
        @(negedge clk);
        req_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("rst_wait");
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("stale_rvalid_rsp", {31'd0, rsp_valid}, 32'd0);
        do_access(0, 3'b100, 0, 32'h7004, 0, 0, 0, 32'h600D_F00D, 0, 32'h600D_F00D, 32'h7004, 4'b0000, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store memory controller consuming the one-hot access size mode (byte/half/word) produced from funct3[1:0] in decode, plus the signedness bit funct3[2]. It accepts one access per request handshake, issues a single word-aligned memory transaction with byte strobes, and returns aligned, sign- or zero-extended load data to the writeback stage. It sits between the execute/MEM pipeline stage and the data-memory port. It guards the memory port with alignment checking and a response timeout.

## Interface
- ADDR_W, 32, byte address width; data path fixed at 32 bits
- TIMEOUT, 255, maximum cycles in WAIT before an error response; must be 1..65535
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  access request
- req_ready  out  1  controller can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_mode  in  3  one-hot size: 001 byte, 010 half, 100 word
- req_unsigned  in  1  load zero-extend (funct3[2]); ignored for stores
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-justified
- mem_valid  out  1  memory transaction request
- mem_ready  in  1  memory accepts transaction
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word address, bits [1:0] = 0
- mem_wstrb  out  4  byte strobes, 0000 for loads
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  raw load word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data, 0 for stores/errors
- rsp_err  out  1  misaligned, illegal mode, or timeout

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. When req_valid is high, latch all req_* fields and go to REQ. With an error check failing (see Configuration), go to RESP with err=1 instead.
- REQ: mem_valid=1, and all mem_* outputs are stable until mem_ready. On handshake:
  - Store: go to RESP.
  - Load with mem_rvalid high in the same cycle: capture the data and go to RESP.
  - Otherwise load: go to WAIT. Clear the timeout counter.
- WAIT: the counter increments each cycle.
  - On mem_rvalid: capture the data and go to RESP.
  - On counter reaching TIMEOUT: go to RESP with err=1 and rdata=0.
- RESP: rsp_valid=1 for exactly one cycle, with no backpressure. Then go to IDLE.
- Store lanes, using latched addr[1:0]:
  - Byte: wstrb=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - Half: wstrb=0011<<{addr[1],0}, wdata={2{wdata[15:0]}}.
  - Word: wstrb=1111, wdata unchanged.
- Load extract:
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Extension is sign or zero per req_unsigned.
  - Word: passes through unchanged.
- mem_rvalid outside REQ/WAIT is ignored.
- Reset: state=IDLE.
  - mem_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - req_ready=1 after the reset edge.
  - Reset mid-transaction abandons the access with no response. A stale rvalid arriving afterwards is ignored.

## Timing
- Cycle 0: request accepted. Cycle 1: mem_valid high.
- Store with mem_ready in cycle 1: rsp_valid in cycle 2.
- Load with mem_ready and rvalid in cycle 1: rsp_valid in cycle 2.
- Load with rvalid in cycle 1+k: rsp_valid in cycle 2+k.
- Error request accepted in cycle 0: rsp_valid in cycle 1, and mem_valid never asserts.
- Timeout: rsp_valid TIMEOUT+1 cycles after the WAIT entry.
- Back-to-back: the next request can be accepted in the cycle after rsp_valid.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - Half with addr[0]=1 sets rsp_err.
  - Word with addr[1:0]!=0 sets rsp_err.
  - Non-one-hot mode sets rsp_err.
  - In all these cases no memory transaction is issued.
- LSU_ALIGN_CHECK_EN undefined:
  - Low address bits below the access size are treated as zero.
  - A non-one-hot mode is treated as word.
  - rsp_err is asserted only on timeout.

## Structure
- Package lsu_pkg holds:
  - MODE_B/MODE_H/MODE_W one-hot constants.
  - The state enum.
  - The strobe function.
- Sub-module lsu_align is combinational and performs strobe/replicate on stores and extract/extend on loads. The FSM, counter, and registers live in lsu_mem_ctrl.

## Test plan
- Store byte, addr 0x1003, wdata 0x000000A5, mem_ready in cycle 1 -> mem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5, rsp_valid in cycle 2, err=0.
- Load half signed, addr 0x2002, rdata 0x8001_1234, rvalid 3 cycles after handshake -> rsp_rdata=0xFFFF8001.
  - Same access with req_unsigned=1 -> 0x00008001.
- Load word, mem_ready delayed 4 cycles -> mem_* stable throughout, wstrb=0000, single rsp_valid pulse.
- With LSU_ALIGN_CHECK_EN, load word addr 0x3001 -> mem_valid never high, rsp_valid in cycle 1 with err=1.
  - Mode 011 behaves the same.
- TIMEOUT=4, load with no rvalid -> rsp_err=1, rdata=0, rsp_valid 5 cycles after WAIT entry.
  - A late rvalid in IDLE is ignored.
- rst asserted while in WAIT -> all outputs at reset values next cycle, no rsp_valid, new request accepted cleanly.
